// File: rtl/demux2_stream_pkg.sv
// demux2_stream shared types and constants.
// Channel select encoding and default word type.
package demux2_pkg;

  localparam int WIDTH_DEFAULT = 5;

  localparam logic CH0 = 1'b0;
  localparam logic CH1 = 1'b1;

  typedef logic [WIDTH_DEFAULT-1:0] word_t;

endpackage

// File: rtl/demux2_stream_if.sv
// Stream bundle for the 1-to-2 demux: one input
// stream, two output streams, delivered-word counters.
interface demux2_stream_if #(
  parameter int WIDTH = 5,
  parameter int CNTW  = 8
);

  logic [WIDTH-1:0] in_data;
  logic             in_sel;
  logic             in_valid;
  logic             in_ready;

  logic [WIDTH-1:0] out0_data;
  logic             out0_valid;
  logic             out0_ready;

  logic [WIDTH-1:0] out1_data;
  logic             out1_valid;
  logic             out1_ready;

  logic [CNTW-1:0]  cnt0;
  logic [CNTW-1:0]  cnt1;

  modport master (
    output in_data, in_sel, in_valid,
    output out0_ready, out1_ready,
    input  in_ready,
    input  out0_data, out0_valid,
    input  out1_data, out1_valid,
    input  cnt0, cnt1
  );

  modport slave (
    input  in_data, in_sel, in_valid,
    input  out0_ready, out1_ready,
    output in_ready,
    output out0_data, out0_valid,
    output out1_data, out1_valid,
    output cnt0, cnt1
  );

endinterface

// File: rtl/demux_chan_fifo.sv
// Per-channel FIFO of the demux: storage, pointers,
// occupancy, full/valid flags and delivered counter.
module demux_chan_fifo
  import demux2_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT,
  parameter int DEPTH = 2,
  parameter int CNTW  = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             ready,
  output logic             full,
  output logic             valid,
  output logic [WIDTH-1:0] data,
  output logic [CNTW-1:0]  cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULLC = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic [CW-1:0]    count;

  logic do_push;
  logic do_pop;

  assign full    = (count == FULLC);
  assign valid   = (count != '0);
  assign data    = mem[rptr];
  assign do_push = push & ~full;
  assign do_pop  = ready & valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++)
        mem[i] <= '0;
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      cnt   <= '0;
    end else begin
      if (do_push) begin
        mem[wptr] <= wdata;
        wptr      <= wptr + 1'b1;
      end
      if (do_pop) begin
        rptr <= rptr + 1'b1;
        cnt  <= cnt + 1'b1;
      end
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/demux2_stream.sv
// Registered 1-to-2 stream demux: steers each accepted
// word into one of two independently drained FIFOs.
module demux2_stream
  import demux2_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT,
  parameter int DEPTH = 2,
  parameter int CNTW  = 8
) (
  input logic            clk,
  input logic            rst_n,
  demux2_stream_if.slave bus
);

  logic full0;
  logic full1;
  logic push0;
  logic push1;

  // in_ready only sees registered full flags, never out*_ready
  always_comb begin
    push0        = 1'b0;
    push1        = 1'b0;
    bus.in_ready = 1'b1;
    unique case (bus.in_sel)
      CH0: begin
        bus.in_ready = ~full0;
        push0        = bus.in_valid & ~full0;
      end
      CH1: begin
        bus.in_ready = ~full1;
        push1        = bus.in_valid & ~full1;
      end
      default: ;
    endcase
  end

  demux_chan_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .CNTW  (CNTW)
  ) u_ch0 (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push0),
    .wdata (bus.in_data),
    .ready (bus.out0_ready),
    .full  (full0),
    .valid (bus.out0_valid),
    .data  (bus.out0_data),
    .cnt   (bus.cnt0)
  );

  demux_chan_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .CNTW  (CNTW)
  ) u_ch1 (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push1),
    .wdata (bus.in_data),
    .ready (bus.out1_ready),
    .full  (full1),
    .valid (bus.out1_valid),
    .data  (bus.out1_data),
    .cnt   (bus.cnt1)
  );

endmodule
